fpro_bus_arbiter: RTL and testbench



---
 rtl/fpro_arb_pkg.sv | 22 ++
 rtl/fpro_arb_pick.sv | 26 ++
 rtl/fpro_bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_fpro_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpro_arb_pkg.sv
// Shared types for the two-master FPro bus arbiter.
package fpro_arb_pkg;

    // Widest address/data a latched command can carry; the arbiter's
    // ADDR_W/DATA_W must not exceed these.
    localparam int FP_ADDR_W = 21;
    localparam int FP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef struct packed {
        logic                 video_sel;
        logic                 wr;
        logic [FP_ADDR_W-1:0] addr;
        logic [FP_DATA_W-1:0] wr_data;
    } fpro_cmd_t;

endpackage

// File: rtl/fpro_arb_pick.sv
// Combinational winner select for two requesters.
// A pending lock hold overrides the tie rule; otherwise PRIO_MODE decides ties.
module fpro_arb_pick #(
    parameter int PRIO_MODE = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       hold_vld,
    input  logic       hold_id,
    output logic       grant,
    output logic       valid
);

    // Pick a winner: lock hold first, then tie rule, then the lone requester
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (hold_vld && req[hold_id])
            grant = hold_id;
        else if (req == 2'b11)
            grant = (PRIO_MODE == 1) ? 1'b0 : ~last_grant;
        else
            grant = req[1] & ~req[0];
    end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Two-master arbiter for the FPro bus (m0 = MCS bridge, m1 = DMA/blitter).
// IDLE -> ACCESS (one-cycle strobes) -> ACK (ack pulse, re-arbitrate).
// Optional macro FPRO_ARB_LOCK_EN: a master holding lock keeps the bus for
// up to MAX_LOCK consecutive transactions.
module fpro_bus_arbiter
    import fpro_arb_pkg::*;
#(
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0,
    parameter int MAX_LOCK  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_video_sel,
    input  logic              m1_video_sel,
    input  logic              m0_wr,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m0_lock,
    input  logic              m1_lock,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              fp_mmio_cs,
    output logic              fp_video_cs,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [DATA_W-1:0] fp_wr_data,
    input  logic [DATA_W-1:0] fp_rd_data,
    output logic              owner
);

    state_t                   state, state_nxt;
    fpro_cmd_t                cmd_m0, cmd_m1, win_cmd;
    logic [1:0]               req, req_arb, own_mask;
    logic                     last_grant;
    logic                     pick_grant, pick_vld;
    logic                     latch;
    logic                     hold_vld;
    logic                     lock_take;
    logic [1:0][DATA_W-1:0]   rd_q;

    assign req      = {m1_req, m0_req};
    assign own_mask = owner ? 2'b10 : 2'b01;
    // The master being acked still has req high for the finished command.
    assign req_arb  = (state == ACK) ? (req & ~own_mask) : req;

    // Pack each master's command for latching
    always_comb begin
        cmd_m0           = '0;
        cmd_m0.video_sel = m0_video_sel;
        cmd_m0.wr        = m0_wr;
        cmd_m0.addr      = FP_ADDR_W'(m0_addr);
        cmd_m0.wr_data   = FP_DATA_W'(m0_wr_data);
        cmd_m1           = '0;
        cmd_m1.video_sel = m1_video_sel;
        cmd_m1.wr        = m1_wr;
        cmd_m1.addr      = FP_ADDR_W'(m1_addr);
        cmd_m1.wr_data   = FP_DATA_W'(m1_wr_data);
    end

    assign win_cmd = pick_grant ? cmd_m1 : cmd_m0;

    fpro_arb_pick #(.PRIO_MODE(PRIO_MODE)) u_pick (
        .req        (req_arb),
        .last_grant (last_grant),
        .hold_vld   (hold_vld),
        .hold_id    (owner),
        .grant      (pick_grant),
        .valid      (pick_vld)
    );

`ifdef FPRO_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [CNT_W:0]   cnt_inc;
    logic             hold_q, hold_nxt;
    logic             own_lock;

    assign own_lock  = owner ? m1_lock : m0_lock;
    assign cnt_inc   = {1'b0, lock_cnt} + 1'b1;
    assign lock_take = hold_nxt;
    assign hold_vld  = hold_q && (state == IDLE);

    // Lock bookkeeping: count locked ACKs, drop the lock once at the limit
    always_comb begin
        lock_cnt_nxt = lock_cnt;
        hold_nxt     = 1'b0;
        if (state == ACK) begin
            if (own_lock && (cnt_inc < (CNT_W+1)'(MAX_LOCK))) begin
                lock_cnt_nxt = cnt_inc[CNT_W-1:0];
                hold_nxt     = 1'b1;
            end else begin
                lock_cnt_nxt = '0;
            end
        end else if (latch && (pick_grant != owner)) begin
            lock_cnt_nxt = '0;
        end
    end

    // Lock counter and one-cycle hold for the IDLE arbitration after ACK
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= '0;
            hold_q   <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_nxt;
            hold_q   <= hold_nxt;
        end
    end
`else
    localparam int unused_max_lock = MAX_LOCK;
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
    assign lock_take   = 1'b0;
    assign hold_vld    = 1'b0;
`endif

    // Next-state: grant from IDLE or straight out of ACK
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = ACCESS;
                    latch     = 1'b1;
                end
            end
            ACCESS: state_nxt = ACK;
            ACK: begin
                if (pick_vld && !lock_take) begin
                    state_nxt = ACCESS;
                    latch     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FPro strobes are loaded on grant and are zero outside ACCESS
    always_ff @(posedge clk) begin
        if (reset || !latch) begin
            fp_mmio_cs  <= 1'b0;
            fp_video_cs <= 1'b0;
            fp_wr       <= 1'b0;
            fp_rd       <= 1'b0;
            fp_addr     <= '0;
            fp_wr_data  <= '0;
        end else begin
            fp_mmio_cs  <= ~win_cmd.video_sel;
            fp_video_cs <= win_cmd.video_sel;
            fp_wr       <= win_cmd.wr;
            fp_rd       <= ~win_cmd.wr;
            fp_addr     <= ADDR_W'(win_cmd.addr);
            fp_wr_data  <= DATA_W'(win_cmd.wr_data);
        end
    end

    // Owner follows each grant; last_grant updates as the owner is acked
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (latch)         owner      <= pick_grant;
            if (state == ACK)  last_grant <= owner;
        end
    end

    // Ack pulses during ACK; read data captured at the end of ACCESS
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            rd_q   <= '0;
        end else begin
            m0_ack <= (state == ACCESS) && !owner;
            m1_ack <= (state == ACCESS) &&  owner;
            if ((state == ACCESS) && fp_rd)
                rd_q[owner] <= fp_rd_data;
        end
    end

    assign m0_rd_data = rd_q[0];
    assign m1_rd_data = rd_q[1];

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Bench for fpro_bus_arbiter: two instances (round-robin and fixed
// priority) share stimulus; a transaction-level model predicts every
// output each cycle, and directed literal checks pin the model.
module tb_fpro_bus_arbiter;
    localparam int AW = 21;
    localparam int DW = 32;
    localparam int ML = 4;
`ifdef FPRO_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic [1:0]          req = '0, vsel = '0, wr = '0, lock = '0;
    logic [1:0][AW-1:0]  addr = '0;
    logic [1:0][DW-1:0]  wdat = '0;
    logic [DW-1:0]       rd_val = '0;

    logic [1:0]               mmio_cs, video_cs, fwr, frd, own;
    logic [1:0][AW-1:0]       faddr;
    logic [1:0][DW-1:0]       fwd;
    logic [1:0][1:0]          ack;
    logic [1:0][1:0][DW-1:0]  rdd;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    // Instance index equals its PRIO_MODE
    for (genvar p = 0; p < 2; p++) begin : g_dut
        fpro_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(p), .MAX_LOCK(ML)) dut (
            .clk(clk), .reset(reset),
            .m0_req(req[0]), .m1_req(req[1]),
            .m0_video_sel(vsel[0]), .m1_video_sel(vsel[1]),
            .m0_wr(wr[0]), .m1_wr(wr[1]),
            .m0_addr(addr[0]), .m1_addr(addr[1]),
            .m0_wr_data(wdat[0]), .m1_wr_data(wdat[1]),
            .m0_lock(lock[0]), .m1_lock(lock[1]),
            .m0_ack(ack[p][0]), .m1_ack(ack[p][1]),
            .m0_rd_data(rdd[p][0]), .m1_rd_data(rdd[p][1]),
            .fp_mmio_cs(mmio_cs[p]), .fp_video_cs(video_cs[p]),
            .fp_wr(fwr[p]), .fp_rd(frd[p]),
            .fp_addr(faddr[p]), .fp_wr_data(fwd[p]),
            .fp_rd_data(rd_val), .owner(own[p])
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    // age: 0 = bus free, 1 = transaction on the bus, 2 = transaction being acked
    int age[2], cur[2], lg[2], hold[2], lcnt[2];
    logic                    cur_wr[2];
    logic [1:0]              e_mmio, e_vid, e_wr, e_rd, e_own;
    logic [1:0][AW-1:0]      e_addr;
    logic [1:0][DW-1:0]      e_wd;
    logic [1:0][1:0]         e_ack;
    logic [1:0][1:0][DW-1:0] e_rdd;

    function automatic int pick(input int p, input logic [1:0] rq);
        if (rq == 2'b11) return (p == 1) ? 0 : 1 - lg[p];
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        return -1;
    endfunction

    task automatic grant(input int p, input int m);
        if (m != int'(e_own[p])) lcnt[p] = 0;
        cur[p] = m; cur_wr[p] = wr[m]; age[p] = 1; e_own[p] = m[0];
        e_mmio[p] = ~vsel[m]; e_vid[p] = vsel[m];
        e_wr[p] = wr[m]; e_rd[p] = ~wr[m];
        e_addr[p] = addr[m]; e_wd[p] = wdat[m];
    endtask

    task automatic model_step(input int p);
        int w;
        logic [1:0] rq;
        bit locked;
        e_mmio[p] = 1'b0; e_vid[p] = 1'b0; e_wr[p] = 1'b0; e_rd[p] = 1'b0;
        e_addr[p] = '0; e_wd[p] = '0; e_ack[p] = '0;
        if (reset) begin
            age[p] = 0; lg[p] = 1; hold[p] = -1; lcnt[p] = 0; cur[p] = 0;
            e_own[p] = 1'b0; e_rdd[p] = '0;
        end else if (age[p] == 1) begin
            if (!cur_wr[p]) e_rdd[p][cur[p]] = rd_val;
            e_ack[p][cur[p]] = 1'b1;
            age[p] = 2;
        end else begin
            rq = req; w = -1;
            if (age[p] == 2) begin
                lg[p] = cur[p]; locked = 1'b0;
                if (LOCK_EN && lock[cur[p]]) begin
                    lcnt[p]++;
                    if (lcnt[p] >= ML) lcnt[p] = 0;
                    else locked = 1'b1;
                end else lcnt[p] = 0;
                rq[cur[p]] = 1'b0;
                hold[p] = locked ? cur[p] : -1;
                if (!locked) w = pick(p, rq);
            end else begin
                if (hold[p] >= 0 && rq[hold[p]]) w = hold[p];
                else w = pick(p, rq);
                hold[p] = -1;
            end
            age[p] = 0;
            if (w >= 0) grant(p, w);
        end
    endtask

    task automatic cmp_all();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("d%0d fp_mmio_cs", p), mmio_cs[p], e_mmio[p]);
            chk($sformatf("d%0d fp_video_cs", p), video_cs[p], e_vid[p]);
            chk($sformatf("d%0d fp_wr", p), fwr[p], e_wr[p]);
            chk($sformatf("d%0d fp_rd", p), frd[p], e_rd[p]);
            chk($sformatf("d%0d fp_addr", p), faddr[p], e_addr[p]);
            chk($sformatf("d%0d fp_wr_data", p), fwd[p], e_wd[p]);
            chk($sformatf("d%0d acks", p), ack[p], e_ack[p]);
            chk($sformatf("d%0d owner", p), own[p], e_own[p]);
            chk($sformatf("d%0d m0_rd_data", p), rdd[p][0], e_rdd[p][0]);
            chk($sformatf("d%0d m1_rd_data", p), rdd[p][1], e_rdd[p][1]);
        end
    endtask

    // Model advances on each edge; outputs compared on the falling edge
    initial begin
        forever begin
            @(posedge clk);
            for (int p = 0; p < 2; p++) model_step(p);
            @(negedge clk);
            cmp_all();
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int c0, c1, n0, n1;

        repeat (2) @(negedge clk);
        chk("rst strobes", {mmio_cs, video_cs, fwr, frd}, 8'h00);
        chk("rst fp_addr", faddr, '0);
        chk("rst acks", ack, 4'h0);
        chk("rst owner", own, 2'b00);
        chk("rst m0_rd_data", {rdd[1][0], rdd[0][0]}, '0);

        // m0 write to mmio
        reset = 1'b0;
        req[0] = 1'b1; vsel[0] = 1'b0; wr[0] = 1'b1;
        addr[0] = 21'h00040; wdat[0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr access strobes", {mmio_cs, fwr, video_cs, frd}, 8'b11_11_00_00);
        chk("wr fp_addr", faddr[0], 21'h00040);
        chk("wr fp_wr_data", fwd[1], 32'hDEADBEEF);
        @(negedge clk);
        chk("wr m0_ack", {ack[1], ack[0]}, 4'b0101);
        chk("wr strobes cleared", {mmio_cs, fwr, video_cs, frd}, 8'h00);
        @(negedge clk);
        req[0] = 1'b0;

        // m1 read from video space
        req[1] = 1'b1; vsel[1] = 1'b1; wr[1] = 1'b0;
        addr[1] = 21'h1FFFF; rd_val = 32'h0000_0ABC;
        @(negedge clk);
        chk("rd access strobes", {video_cs, frd, mmio_cs, fwr}, 8'b11_11_00_00);
        chk("rd fp_addr", faddr[1], 21'h1FFFF);
        @(negedge clk);
        chk("rd m1_ack", {ack[1], ack[0]}, 4'b1010);
        chk("rd m1_rd_data", rdd[0][1], 32'h0000_0ABC);
        @(negedge clk);
        req[1] = 1'b0; rd_val = 32'h1234_5678;
        repeat (3) @(negedge clk);
        chk("rd data held", rdd[1][1], 32'h0000_0ABC);

        // m0 read must not disturb m1's held data
        req[0] = 1'b1; vsel[0] = 1'b1; wr[0] = 1'b0; addr[0] = 21'h00007;
        rd_val = 32'h55AA_55AA;
        repeat (2) @(negedge clk);
        chk("m0 rd data", rdd[0][0], 32'h55AA_55AA);
        chk("m1 rd still held", rdd[0][1], 32'h0000_0ABC);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Both requesting; m0 was last served. Round-robin starts with m1,
        // fixed priority with m0; the acked master sits out its own ACK so
        // both instances then alternate.
        req = 2'b11; vsel = 2'b00; wr = 2'b11;
        addr[0] = 21'h00010; addr[1] = 21'h00020;
        wdat[0] = 32'h1111_1111; wdat[1] = 32'h2222_2222;
        c0 = 0; c1 = 0; n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (|ack[0]) begin c0 = c0 * 10 + (ack[0][1] ? 2 : 1); n0++; end
            if (|ack[1]) begin c1 = c1 * 10 + (ack[1][1] ? 2 : 1); n1++; end
        end
        chk("rr ack order", c0, 2121);
        chk("prio ack order", c1, 1212);
        chk("ack rate", n0 + n1, 8);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Reset during ACCESS of an m1 write
        req[1] = 1'b1; wr[1] = 1'b1; vsel[1] = 1'b0;
        addr[1] = 21'h00123; wdat[1] = 32'hCAFE_F00D;
        @(negedge clk);
        chk("pre-reset access", {mmio_cs, fwr}, 4'b1111);
        reset = 1'b1;
        @(negedge clk);
        chk("abort no ack", ack, 4'h0);
        chk("abort strobes", {mmio_cs, video_cs, fwr, frd}, 8'h00);
        chk("abort fp_wr_data", fwd, '0);
        chk("abort owner", own, 2'b00);
        reset = 1'b0; req[1] = 1'b0;
        @(negedge clk);
        chk("post-reset idle", {ack, mmio_cs, fwr}, 8'h00);
        @(negedge clk);

        // m0 holds lock while both request
        lock[0] = 1'b1; req = 2'b11; wr = 2'b11;
        c0 = 0; c1 = 0; n0 = 0; n1 = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (|ack[0]) begin if (n0 < 6) c0 = c0 * 10 + (ack[0][1] ? 2 : 1); n0++; end
            if (|ack[1]) begin if (n1 < 6) c1 = c1 * 10 + (ack[1][1] ? 2 : 1); n1++; end
        end
`ifdef FPRO_ARB_LOCK_EN
        chk("lock ack order rr", c0, 111121);
        chk("lock ack order prio", c1, 111121);
`else
        chk("lock ignored rr", c0, 121212);
        chk("lock ignored prio", c1, 121212);
`endif
        req = 2'b00; lock = 2'b00;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
